// File: rtl/prog_loader_if.sv
// Byte-stream input and word-write memory port of the program loader.
// master: the loader (consumes bytes, drives writes); slave: receiver/memory side.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int WORD_BYTES = 4
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [8*WORD_BYTES-1:0] mem_data;
    logic                    mem_we;

    modport master (
        input  rx_data, rx_valid,
        output mem_addr, mem_data, mem_we
    );

    modport slave (
        output rx_data, rx_valid,
        input  mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/prog_loader.sv
// UART-fed loader: 4-byte word-count header, then payload assembled into words and written out.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
    parameter int ADDR_WIDTH = 17,
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    prog_loader_if.master       bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] word_count
);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;
`endif

    state_t                 state_q, state_d;
    logic [1:0]             hdr_cnt_q, hdr_cnt_d;
    logic [31:0]            len_q, len_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [WORD_W-1:0]      buf_q, buf_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   we_q, we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [ADDR_WIDTH:0]    wc_q, wc_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    logic [LANE_W-1:0]      lane_sel;
    logic [ADDR_WIDTH:0]    next_count;
    logic [31:0]            hdr_len;

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        len_d      = len_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        wc_d       = wc_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        lane_sel   = BIG_ENDIAN ? (LAST_LANE - lane_q) : lane_q;
        next_count = wc_q + 1'b1;
        hdr_len    = BIG_ENDIAN ? {len_q[23:0], bus.rx_data} : {bus.rx_data, len_q[31:8]};

        case (state_q)
            IDLE, DONE: begin
                // busy still high in DONE means the session just ended: publish done now
                if (busy_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (start) begin
                    state_d   = HEADER;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    wc_d      = '0;
                    hdr_cnt_d = '0;
                    lane_d    = '0;
                    len_d     = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d     = '0;
`endif
                end
            end
            HEADER: begin
                if (bus.rx_valid) begin
                    len_d     = hdr_len;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        if (hdr_len == 32'd0) begin
                            state_d = DONE;
                        end else if ({1'b0, hdr_len} > MAX_WORDS) begin
                            state_d = DONE;
                            error_d = 1'b1;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    for (int k = 0; k < WORD_BYTES; k++) begin
                        if (LANE_W'(k) == lane_sel) buf_d[8*k +: 8] = bus.rx_data;
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d = sum_q ^ bus.rx_data;
`endif
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        data_d = buf_d;
                        addr_d = wc_q[ADDR_WIDTH-1:0];
                        we_d   = 1'b1;
                        wc_d   = next_count;
                        if (next_count == len_q[ADDR_WIDTH:0]) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                if (bus.rx_valid) begin
                    error_d = (bus.rx_data != sum_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            hdr_cnt_q <= '0;
            len_q     <= '0;
            lane_q    <= '0;
            buf_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wc_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            len_q     <= len_d;
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            wc_q      <= wc_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.mem_we   = we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign word_count   = wc_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: little- and big-endian instances driven with the same sessions,
// writes captured at the memory port and compared against words built from the byte stream.
module tb_prog_loader;
    localparam int AW = 4;
    localparam int WB = 4;
    localparam int MAXN = 1 << AW;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic start = 1'b0;
    logic busy_le, done_le, error_le, busy_be, done_be, error_be;
    logic [AW:0] wc_le, wc_be;

    prog_loader_if #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) bus_le ();
    prog_loader_if #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) bus_be ();

    prog_loader #(.ADDR_WIDTH(AW), .WORD_BYTES(WB), .BIG_ENDIAN(1'b0)) u_le (
        .CLK(CLK), .RST_N(RST_N), .start(start), .bus(bus_le.master),
        .busy(busy_le), .done(done_le), .error(error_le), .word_count(wc_le)
    );
    prog_loader #(.ADDR_WIDTH(AW), .WORD_BYTES(WB), .BIG_ENDIAN(1'b1)) u_be (
        .CLK(CLK), .RST_N(RST_N), .start(start), .bus(bus_be.master),
        .busy(busy_be), .done(done_be), .error(error_be), .word_count(wc_be)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [8*WB-1:0] data;
        int unsigned     cyc;
    } wr_t;

    wr_t got_le[$], got_be[$], exp_le[$], exp_be[$];
    logic [7:0] pl[$];
    int unsigned cyc = 0;
    int unsigned sent_cyc;
    int nvec = 0;
    int nfail = 0;
    logic [8*WB-1:0] first_le, first_be;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus_le.mem_we === 1'b1) got_le.push_back('{bus_le.mem_addr, bus_le.mem_data, cyc});
        if (bus_be.mem_we === 1'b1) got_be.push_back('{bus_be.mem_addr, bus_be.mem_data, cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic b,
                              input int wc);
        check({tag, "_done_le"}, 64'(done_le), 64'(d));
        check({tag, "_done_be"}, 64'(done_be), 64'(d));
        check({tag, "_err_le"}, 64'(error_le), 64'(e));
        check({tag, "_err_be"}, 64'(error_be), 64'(e));
        check({tag, "_busy_le"}, 64'(busy_le), 64'(b));
        check({tag, "_busy_be"}, 64'(busy_be), 64'(b));
        check({tag, "_wc_le"}, 64'(wc_le), 64'(wc));
        check({tag, "_wc_be"}, 64'(wc_be), 64'(wc));
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_addr_le"}, 64'(bus_le.mem_addr), 64'd0);
        check({tag, "_data_le"}, 64'(bus_le.mem_data), 64'd0);
        check({tag, "_we_le"}, 64'(bus_le.mem_we), 64'd0);
        check({tag, "_addr_be"}, 64'(bus_be.mem_addr), 64'd0);
        check({tag, "_data_be"}, 64'(bus_be.mem_data), 64'd0);
        check({tag, "_we_be"}, 64'(bus_be.mem_we), 64'd0);
        chk_status(tag, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic send(input logic [7:0] ble, input logic [7:0] bbe, input int gap,
                        input bit with_start);
        bus_le.rx_data = ble;
        bus_be.rx_data = bbe;
        bus_le.rx_valid = 1'b1;
        bus_be.rx_valid = 1'b1;
        start = with_start;
        sent_cyc = cyc;
        @(negedge CLK);
        bus_le.rx_valid = 1'b0;
        bus_be.rx_valid = 1'b0;
        start = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwr_le"}, 64'(got_le.size()), 64'(exp_le.size()));
        check({tag, "_nwr_be"}, 64'(got_be.size()), 64'(exp_be.size()));
        for (int i = 0; i < exp_le.size() && i < got_le.size(); i++) begin
            check({tag, "_addr_le"}, 64'(got_le[i].addr), 64'(exp_le[i].addr));
            check({tag, "_data_le"}, 64'(got_le[i].data), 64'(exp_le[i].data));
            check({tag, "_lat_le"}, 64'(got_le[i].cyc), 64'(exp_le[i].cyc));
        end
        for (int i = 0; i < exp_be.size() && i < got_be.size(); i++) begin
            check({tag, "_addr_be"}, 64'(got_be[i].addr), 64'(exp_be[i].addr));
            check({tag, "_data_be"}, 64'(got_be[i].data), 64'(exp_be[i].data));
            check({tag, "_lat_be"}, 64'(got_be[i].cyc), 64'(exp_be[i].cyc));
        end
        if (got_le.size() > 0) first_le = got_le[0].data;
        if (got_be.size() > 0) first_be = got_be[0].data;
        got_le.delete(); got_be.delete(); exp_le.delete(); exp_be.delete();
    endtask

    // Full session: start, header encoding n per instance byte order, payload from pl.
    task automatic run_session(input string tag, input int n, input int gap_max,
                               input int start_at, input bit bad_sum);
        logic [31:0] nv;
        logic [63:0] wle, wbe;
        logic [7:0]  sum;
        int nwords;
        nv = 32'(n);
        nwords = (n >= 1 && n <= MAXN) ? n : 0;
        wle = '0; wbe = '0; sum = '0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk_status({tag, "_start"}, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            send(nv[8*i +: 8], nv[8*(3-i) +: 8], (i == 3) ? 0 : $urandom_range(gap_max, 0), 1'b0);
        if (nwords == 0) begin
            check({tag, "_hdr_done_early"}, 64'(done_le), 64'd0);
            @(negedge CLK);
            chk_status({tag, "_hdr_end"}, 1'b1, (n != 0), 1'b0, 0);
        end else begin
            for (int i = 0; i < 4 * nwords; i++) begin
                wle = wle | (64'(pl[i]) << (8 * (i % WB)));
                wbe = (wbe << 8) | 64'(pl[i]);
                sum = sum ^ pl[i];
                send(pl[i], pl[i], (i == 4 * nwords - 1) ? 0 : $urandom_range(gap_max, 0),
                     (i == start_at));
                if (i % WB == WB - 1) begin
                    exp_le.push_back('{AW'(i / WB), (8*WB)'(wle), sent_cyc + 1});
                    exp_be.push_back('{AW'(i / WB), (8*WB)'(wbe), sent_cyc + 1});
                    wle = '0; wbe = '0;
                end
            end
            check({tag, "_done_early"}, 64'(done_le), 64'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
            send(sum ^ {7'd0, bad_sum}, sum ^ {7'd0, bad_sum}, 0, 1'b0);
            chk_status({tag, "_sum_end"}, 1'b1, bad_sum, 1'b0, n);
`else
            @(negedge CLK);
            chk_status({tag, "_end"}, 1'b1, 1'b0, 1'b0, n);
`endif
        end
        compare_writes(tag);
    endtask

    initial begin
        bus_le.rx_data = '0; bus_le.rx_valid = 1'b0;
        bus_be.rx_data = '0; bus_be.rx_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 0, 1'b0);
        @(negedge CLK);
        check("idle_nwr", 64'(got_le.size() + got_be.size()), 64'd0);
        chk_status("idle", 1'b0, 1'b0, 1'b0, 0);

        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_session("dir2", 2, 2, -1, 1'b0);
        check("dir2_w0_le", 64'(first_le), 64'h44332211);
        check("dir2_w0_be", 64'(first_be), 64'h11223344);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(MAXN, 1);
            fill_random(n);
            run_session("rand", n, 3, -1, 1'b0);
        end

        fill_random(3);
        run_session("b2b_start", 3, 0, 5, 1'b0);

        run_session("n0", 0, 1, -1, 1'b0);

        fill_random(MAXN);
        run_session("nmax", MAXN, 1, -1, 1'b0);

        run_session("n17", MAXN + 1, 0, -1, 1'b0);
        for (int i = 0; i < 8; i++) send(8'($urandom), 8'($urandom), 0, 1'b0);
        @(negedge CLK);
        check("n17_after_nwr", 64'(got_le.size() + got_be.size()), 64'd0);
        chk_status("n17_after", 1'b1, 1'b1, 1'b0, 0);

        // Reset after 6 payload bytes of a 2-word session: only word 0 reaches memory.
        fill_random(2);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        send(8'h02, 8'h00, 0, 1'b0); send(8'h00, 8'h00, 0, 1'b0);
        send(8'h00, 8'h00, 0, 1'b0); send(8'h00, 8'h02, 0, 1'b0);
        for (int i = 0; i < 6; i++) send(pl[i], pl[i], 0, 1'b0);
        RST_N = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_mid_nwr_le", 64'(got_le.size()), 64'd1);
        check("rst_mid_nwr_be", 64'(got_be.size()), 64'd1);
        if (got_le.size() > 0) begin
            check("rst_mid_addr", 64'(got_le[0].addr), 64'd0);
            check("rst_mid_data", 64'(got_le[0].data), {32'd0, pl[3], pl[2], pl[1], pl[0]});
        end
        got_le.delete(); got_be.delete();

        fill_random(1);
        run_session("fresh", 1, 1, -1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        pl = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_session("sum_ok", 1, 0, -1, 1'b0);
        pl = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_session("sum_bad", 1, 0, -1, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
